// File: rtl/snake_pkg.sv
// Shared defaults and the write-buffer entry layout for the tile-memory arbiter.
package snake_pkg;
   localparam int AW_DEF    = 10;
   localparam int DW_DEF    = 4;
   localparam int DEPTH_DEF = 4;

   typedef struct packed {
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] data;
   } wr_entry_t;
endpackage

// File: rtl/tile_mem_arbiter_wr_fifo.sv
// Small circular write buffer; the caller guarantees no push when full unless popping.
module wr_fifo #(
   parameter int W     = 14,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through the count.
   always_ff @(posedge clk) mem_q <= mem_d;

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
endmodule

// File: rtl/tile_mem_arbiter.sv
// Single-port tile RAM arbiter: VGA reads always win, SPI writes are buffered and drain when reads pause.
module tile_mem_arbiter
   import snake_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_full,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [7:0]    drop_cnt
);
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [1:0] GNT_IDLE  = 2'd0;
   localparam logic [1:0] GNT_READ  = 2'd1;
   localparam logic [1:0] GNT_WRITE = 2'd2;

   logic [1:0]       grant;
   logic             push, pop;
   logic [AW+DW-1:0] fifo_head;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full, fifo_empty;
   logic [7:0]       drop_cnt_q, drop_cnt_d;
   logic             rd_valid_q, rd_valid_d;

   wr_fifo #(.W(AW + DW), .DEPTH(DEPTH)) u_wr_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({wr_addr, wr_data}),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      if (rd_req)           grant = GNT_READ;
      else if (!fifo_empty) grant = GNT_WRITE;
      else                  grant = GNT_IDLE;
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (grant)
         GNT_READ:  mem_addr = rd_addr;
         GNT_WRITE: begin
            mem_addr  = fifo_head[AW+DW-1:DW];
            mem_wdata = fifo_head[DW-1:0];
            mem_we    = !reset;
         end
         default: ;
      endcase
   end

   // A full buffer still takes a new write when its head drains on the same edge.
   always_comb begin
      pop        = (grant == GNT_WRITE) && !reset;
      push       = wr_req && !reset && (!fifo_full || pop);
      drop_cnt_d = drop_cnt_q;
      if (wr_req && !reset && fifo_full && !pop && drop_cnt_q != 8'hFF)
         drop_cnt_d = drop_cnt_q + 8'd1;
      rd_valid_d = rd_req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign wr_full  = (fifo_count == CW'(DEPTH));
   assign drop_cnt = drop_cnt_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = mem_rdata;
endmodule
